// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD sequence controller: command codes, FSM states,
// digit constants and a nibble validity helper.
package bcd_pkg;

  localparam int          NIB_W     = 4;
  localparam logic [3:0]  MAX_DIGIT = 4'd9;

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_CLEAR = 3'd1,
    OP_LOAD  = 3'd2,
    OP_INC   = 3'd3,
    OP_DEC   = 3'd4,
    OP_RUN   = 3'd5,
    OP_STOP  = 3'd6,
    OP_RSV   = 3'd7
  } cmd_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  function automatic logic nibble_ok(input logic [NIB_W-1:0] n);
    return n <= MAX_DIGIT;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decade (0-9) digit. Carry/borrow in/out are combinational so a chain of
// these forms a ripple BCD up/down counter. Priority: clear, load, inc, dec.
module bcd_digit
  import bcd_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic [NIB_W-1:0] load_val,
  input  logic             inc_in,
  input  logic             dec_in,
  output logic [NIB_W-1:0] digit,
  output logic             inc_out,
  output logic             dec_out
);

  logic [NIB_W-1:0] digit_q, digit_d;

  always_comb begin
    digit_d = digit_q;
    if (clr) begin
      digit_d = '0;
    end else if (load) begin
      digit_d = load_val;
    end else if (inc_in) begin
      digit_d = (digit_q == MAX_DIGIT) ? '0 : digit_q + 4'd1;
    end else if (dec_in) begin
      digit_d = (digit_q == '0) ? MAX_DIGIT : digit_q - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) digit_q <= '0;
    else        digit_q <= digit_d;
  end

  assign digit   = digit_q;
  assign inc_out = inc_in && (digit_q == MAX_DIGIT);
  assign dec_out = dec_in && (digit_q == '0);

endmodule

// File: rtl/bcd_seq_ctrl.sv
// Command-driven multi-digit BCD counter: command decode, IDLE/RUN FSM,
// run-mode prescaler, load validity check and one-cycle status pulses.
module bcd_seq_ctrl
  import bcd_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [2:0]            cmd_op,
  input  logic [4*DIGITS-1:0]   cmd_data,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  running,
  output logic                  done,
  output logic                  wrap,
  output logic                  err
);

  localparam int             PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]  PRESC_LAST = PW'(PRESCALE - 1);

  state_e         state_q, state_d;
  logic [PW-1:0]  presc_q, presc_d;
  logic           done_q, done_d;
  logic           wrap_q, wrap_d;
  logic           err_q, err_d;

  logic           clr, load, inc, dec, tick, load_ok;
  logic [DIGITS-1:0] nib_bad;
  logic [DIGITS:0]   inc_c, dec_c;
  cmd_op_e        op;

  assign op = cmd_op_e'(cmd_op);

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      assign nib_bad[gi] = !nibble_ok(cmd_data[gi*NIB_W +: NIB_W]);

      bcd_digit u_digit (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .load     (load),
        .load_val (cmd_data[gi*NIB_W +: NIB_W]),
        .inc_in   (inc_c[gi]),
        .dec_in   (dec_c[gi]),
        .digit    (bcd_out[gi*NIB_W +: NIB_W]),
        .inc_out  (inc_c[gi+1]),
        .dec_out  (dec_c[gi+1])
      );
    end
  endgenerate

  assign load_ok  = ~|nib_bad;
  assign inc_c[0] = inc;
  assign dec_c[0] = dec;

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    clr     = 1'b0;
    load    = 1'b0;
    inc     = 1'b0;
    dec     = 1'b0;
    tick    = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          case (op)
            OP_NOP, OP_STOP: done_d = 1'b1;
            OP_CLEAR: begin clr = 1'b1; done_d = 1'b1; end
            OP_LOAD: begin
              load   = load_ok;
              done_d = load_ok;
              err_d  = !load_ok;
            end
            OP_INC: begin inc = 1'b1; done_d = 1'b1; end
            OP_DEC: begin dec = 1'b1; done_d = 1'b1; end
            OP_RUN: begin
              state_d = ST_RUN;
              presc_d = '0;
              done_d  = 1'b1;
            end
            default: err_d = 1'b1;
          endcase
        end
      end
      ST_RUN: begin
        tick    = (presc_q == PRESC_LAST);
        presc_d = tick ? '0 : presc_q + PW'(1);
        inc     = tick;
        if (cmd_valid) begin
          case (op)
            OP_NOP: done_d = 1'b1;
            // A coincident tick still lands; the FSM leaves RUN afterwards.
            OP_STOP: begin state_d = ST_IDLE; done_d = 1'b1; end
            OP_CLEAR: begin
              clr     = 1'b1;
              inc     = 1'b0;
              presc_d = '0;
              done_d  = 1'b1;
            end
            default: err_d = 1'b1;
          endcase
        end
      end
      default: state_d = ST_IDLE;
    endcase
    wrap_d = inc_c[DIGITS] | dec_c[DIGITS];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      presc_q <= '0;
      done_q  <= 1'b0;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      done_q  <= done_d;
      wrap_q  <= wrap_d;
      err_q   <= err_d;
    end
  end

  assign cmd_ready = 1'b1;
  assign running   = (state_q == ST_RUN);
  assign done      = done_q;
  assign wrap      = wrap_q;
  assign err       = err_q;

endmodule
